// File: rtl/icache_controller.sv
// Direct-mapped, read-only instruction cache for the Fetch stage.
// Misses are refilled one whole line at a time over a word-wide memory handshake.
module icache_controller #(
  parameter int S = 32,
  parameter int B = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCF,
  output logic [31:0] InstrF,
  output logic        InstrMissF,
  output logic        InstrCacheRepActive,
  output logic        MemReqValid,
  input  logic        MemReqReady,
  output logic [31:0] MemAddr,
  input  logic        MemRespValid,
  input  logic [31:0] MemRespData
);

  localparam int WORDS = B / 4;
  localparam int O     = $clog2(B);
  localparam int I     = $clog2(S);
  localparam int WB    = O - 2;
  localparam int TW    = 32 - O - I;

  localparam logic [WB-1:0] LAST_WORD = WB'(WORDS - 1);
  localparam logic [31:0]   NOP       = 32'h0000_0013;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] FILL   = 2'd2;
  localparam logic [1:0] COMMIT = 2'd3;

  logic [1:0]    state;
  logic [1:0]    stateNext;
  logic [31-O:0] lineAddr;
  logic [WB-1:0] cnt;
  logic [S-1:0]  valid;

  logic [TW-1:0] tagArray  [S];
  logic [31:0]   dataArray [S][WORDS];
  logic [31:0]   fillBuf   [WORDS];

  logic [WB-1:0] word;
  logic [I-1:0]  index;
  logic [TW-1:0] tag;
  logic [I-1:0]  lineSet;
  logic [TW-1:0] lineTag;
  logic          hit;
  logic          unusedPcLow;

  assign word        = PCF[O-1:2];
  assign index       = PCF[O+I-1:O];
  assign tag         = PCF[31:O+I];
  assign lineSet     = lineAddr[I-1:0];
  assign lineTag     = lineAddr[31-O:I];
  assign unusedPcLow = ^PCF[1:0];

  assign hit = valid[index] && (tagArray[index] == tag);

  // Any non-IDLE state stalls fetch, whatever PCF currently points at.
  assign InstrMissF          = (state != IDLE) || !hit;
  assign InstrF              = (state == IDLE && hit) ? dataArray[index][word] : NOP;
  assign MemReqValid         = (state == REQ);
  assign MemAddr             = {lineAddr, {O{1'b0}}};
  assign InstrCacheRepActive = (state == COMMIT);

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (!hit) stateNext = REQ;
      REQ:     if (MemReqReady) stateNext = FILL;
      FILL:    if (MemRespValid && cnt == LAST_WORD) stateNext = COMMIT;
      COMMIT:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      valid    <= '0;
      lineAddr <= '0;
    end else begin
      state <= stateNext;
      // The fill target is captured once; later PCF redirects do not retarget it.
      if (state == IDLE && !hit)
        lineAddr <= PCF[31:O];
      if (state == REQ && MemReqReady)
        cnt <= '0;
      else if (state == FILL && MemRespValid)
        cnt <= cnt + 1'b1;
      if (state == COMMIT)
        valid[lineSet] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == FILL && MemRespValid)
      fillBuf[cnt] <= MemRespData;
    if (state == COMMIT) begin
      tagArray[lineSet] <= lineTag;
      for (int w = 0; w < WORDS; w++)
        dataArray[lineSet][w] <= fillBuf[w];
    end
  end

endmodule

// File: tb/tb_icache_controller.sv
// Scoreboard bench for icache_controller: a line-fill memory model answers requests,
// expected line addresses and instruction words are queued and checked as the cache delivers them.
module tb_icache_controller;

  localparam int WORDS = 4;

  logic        clk;
  logic        reset;
  logic [31:0] PCF;
  logic [31:0] InstrF;
  logic        InstrMissF;
  logic        InstrCacheRepActive;
  logic        MemReqValid;
  logic        MemReqReady;
  logic [31:0] MemAddr;
  logic        MemRespValid;
  logic [31:0] MemRespData;

  icache_controller #(.S(32), .B(16)) dut (
    .clk                 (clk),
    .reset               (reset),
    .PCF                 (PCF),
    .InstrF              (InstrF),
    .InstrMissF          (InstrMissF),
    .InstrCacheRepActive (InstrCacheRepActive),
    .MemReqValid         (MemReqValid),
    .MemReqReady         (MemReqReady),
    .MemAddr             (MemAddr),
    .MemRespValid        (MemRespValid),
    .MemRespData         (MemRespData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;
  int hsCount    = 0;
  int repCount   = 0;
  int readyDelay = 0;
  int respGap    = 0;

  logic [31:0] lineQ[$];
  logic [31:0] instrQ[$];
  logic [31:0] reqAddr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return 32'h0000_00A0 + {2'b00, a[31:2]};
  endfunction

  function automatic int missLatency(input int rd, input int gap);
    return 3 + rd + WORDS * (gap + 1);
  endfunction

  // Line-fill memory: optional ready back-pressure and gaps between response words.
  initial begin : responder
    MemReqReady  = 1'b0;
    MemRespValid = 1'b0;
    MemRespData  = '0;
    forever begin
      @(negedge clk);
      MemReqReady  = 1'b0;
      MemRespValid = 1'b0;
      if (reset && MemReqValid) begin
        reqAddr = MemAddr;
        if (lineQ.size() != 0) chk("reqAddr", MemAddr, lineQ.pop_front());
        else                   chk("reqAddr", MemAddr, 32'hDEAD_BEEF);
        for (int d = 0; d < readyDelay && reset; d++) begin
          @(negedge clk);
          if (reset) begin
            chk("reqHeld", {31'b0, MemReqValid}, 32'd1);
            chk("addrStable", MemAddr, reqAddr);
          end
        end
        if (reset) begin
          MemReqReady = 1'b1;
          @(posedge clk);
          if (reset) begin
            hsCount++;
            for (int w = 0; w < WORDS && reset; w++) begin
              for (int g = 0; g < respGap && reset; g++) begin
                @(negedge clk);
                MemReqReady  = 1'b0;
                MemRespValid = 1'b0;
              end
              @(negedge clk);
              MemReqReady = 1'b0;
              if (reset) begin
                MemRespValid = 1'b1;
                MemRespData  = memWord(reqAddr + 32'(4 * w));
              end
            end
          end
        end
      end
    end
  end

  always @(negedge clk)
    if (reset && InstrCacheRepActive) repCount++;

  int hs0;
  int rep0;

  task automatic issue(input logic [31:0] addr, input bit expMiss);
    hs0  = hsCount;
    rep0 = repCount;
    PCF  = addr;
    if (expMiss) lineQ.push_back({addr[31:4], 4'h0});
    instrQ.push_back(memWord(addr));
  endtask

  task automatic finish(input string tag, input int expRefills, input int expLat);
    int cyc;
    logic [31:0] e;
    #1;
    cyc = 0;
    while (InstrMissF && cyc < 400) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    if (cyc >= 400) chk({tag, "_timeout"}, {31'b0, InstrMissF}, 32'd0);
    e = instrQ.pop_front();
    chk({tag, "_instr"}, InstrF, e);
    chk({tag, "_refills"}, 32'(hsCount - hs0), 32'(expRefills));
    chk({tag, "_commits"}, 32'(repCount - rep0), 32'(expRefills));
    if (expLat >= 0) chk({tag, "_latency"}, 32'(cyc), 32'(expLat));
    $display("fetch %s PCF=%h InstrF=%h stallCycles=%0d", tag, PCF, InstrF, cyc);
  endtask

  task automatic fetch(input string tag, input logic [31:0] addr, input bit expMiss, input int expLat);
    @(negedge clk);
    issue(addr, expMiss);
    finish(tag, expMiss ? 1 : 0, expLat);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : main
    int n;
    reset = 1'b0;
    PCF   = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_miss", {31'b0, InstrMissF}, 32'd1);
    chk("rst_req", {31'b0, MemReqValid}, 32'd0);
    chk("rst_rep", {31'b0, InstrCacheRepActive}, 32'd0);

    // 1. cold miss released straight out of reset
    @(negedge clk);
    issue(32'h0, 1'b1);
    reset = 1'b1;
    finish("cold", 1, missLatency(0, 0));

    // 2. hits in the same line
    fetch("hit4", 32'h4, 1'b0, 0);
    fetch("hit8", 32'h8, 1'b0, 0);
    fetch("hitC", 32'hC, 1'b0, 0);

    // 3. conflict in set 0
    fetch("conf200", 32'h200, 1'b1, missLatency(0, 0));
    fetch("conf000", 32'h0, 1'b1, missLatency(0, 0));
    fetch("conf004", 32'h4, 1'b0, 0);

    // 4. back-pressure and gapped responses
    readyDelay = 5;
    respGap    = 2;
    fetch("bp1F0", 32'h1F0, 1'b1, missLatency(5, 2));
    readyDelay = 0;
    respGap    = 0;
    fetch("bp1F4", 32'h1F4, 1'b0, 0);
    fetch("bp1F8", 32'h1F8, 1'b0, 0);
    fetch("bp1FC", 32'h1FC, 1'b0, 0);

    // 5. redirect during FILL
    @(negedge clk);
    hs0  = hsCount;
    rep0 = repCount;
    PCF  = 32'h40;
    lineQ.push_back(32'h40);
    lineQ.push_back(32'h80);
    instrQ.push_back(memWord(32'h80));
    n = 0;
    while (hsCount == hs0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    PCF = 32'h80;
    finish("redir80", 2, -1);
    fetch("redir40", 32'h44, 1'b0, 0);

    // 6. reset in the middle of FILL
    respGap = 1;
    @(negedge clk);
    hs0 = hsCount;
    PCF = 32'h100;
    lineQ.push_back(32'h100);
    n = 0;
    while (hsCount == hs0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_miss", {31'b0, InstrMissF}, 32'd1);
    chk("midrst_req", {31'b0, MemReqValid}, 32'd0);
    chk("midrst_rep", {31'b0, InstrCacheRepActive}, 32'd0);
    respGap = 0;
    lineQ.delete();
    repeat (2) @(negedge clk);
    issue(32'h40, 1'b1);
    reset = 1'b1;
    finish("postrst40", 1, missLatency(0, 0));
    fetch("postrst100", 32'h10C, 1'b1, missLatency(0, 0));

    repeat (2) @(negedge clk);
    chk("no_stray_req", 32'(lineQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
